misao_mem_ctrl: RTL and testbench
=================================

Name: misao_mem_ctrl

Overview:
- Memory controller directly downstream of the misao core's byte memory port.
- Turns the core's read/write strobes into accesses to a synchronous single-port SRAM with 1-cycle read latency.
- Holds a one-entry byte buffer, so the two nibble fetches the core makes from each byte cost a single SRAM read.
- Decodes two memory-mapped I/O addresses and counts read misses for performance checks.

Parameters:
ADDR_W, 15, byte address width (32 KB space)
DATA_W, 8, data width
IO_OUT_ADDR, 15'h7FFF, address of the write/readback output register
IO_IN_ADDR, 15'h7FFE, address of the synchronised input port (read-only)
SYNC_STAGES, 2, flops in the io_in synchroniser
CNT_W, 16, read-miss counter width

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
core_re  in  1  core read request
core_we  in  1  core write request
core_addr  in  ADDR_W  core byte address
core_wdata  in  DATA_W  core write data
core_rdata  out  DATA_W  read data to core
core_ready  out  1  request completes this cycle
sram_cs  out  1  SRAM chip select
sram_we  out  1  SRAM write enable (valid with sram_cs)
sram_addr  out  ADDR_W  SRAM address
sram_wdata  out  DATA_W  SRAM write data
sram_rdata  in  DATA_W  SRAM read data, valid the cycle after a cs & !we access
io_in  in  DATA_W  asynchronous external input
io_out  out  DATA_W  output register
miss_count  out  CNT_W  saturating read-miss counter

Behaviour:
Clock and reset (already decided):
- One clock, clk; reset rst is asynchronous, active-high.
- While rst is high: state=IDLE, buf_valid=0, io_out=0, miss_count=0, synchroniser flops=0, sram_cs=0, sram_we=0, core_ready=0, core_rdata=0.

States and request acceptance:
- Two states: IDLE and RD_WAIT.
- Requests are sampled only in IDLE. The core holds core_addr, core_re and core_we stable until core_ready=1.
- In IDLE with no request: core_ready=1, core_rdata=buf_data.
- If core_re and core_we are both high, the write wins and the read is dropped; the request completes as a write.

IDLE, write:
- To IO_OUT_ADDR: io_out<=core_wdata; no SRAM access.
- To IO_IN_ADDR: no effect; no SRAM access.
- Otherwise: sram_cs=1, sram_we=1, sram_addr=core_addr, sram_wdata=core_wdata (combinational, same cycle).
  - Write-through: buf_valid<=1, buf_addr<=core_addr, buf_data<=core_wdata.
- core_ready=1 in the same cycle for every write.

IDLE, read:
- IO_OUT_ADDR returns io_out; IO_IN_ADDR returns the last synchroniser stage. Both are combinational, core_ready=1, never buffered.
- Hit (buf_valid && buf_addr==core_addr): core_rdata=buf_data, core_ready=1, sram_cs=0.
- Miss: sram_cs=1, sram_we=0, sram_addr=core_addr, core_ready=0, next state RD_WAIT, miss_count<=miss_count+1 (saturating).

RD_WAIT (always exactly 1 cycle):
- core_rdata=sram_rdata, core_ready=1, sram_cs=0.
- buf_valid<=1, buf_addr<=core_addr, buf_data<=sram_rdata; next state IDLE.

Other rules:
- miss_count sticks at 2^CNT_W-1 once reached.
- rst asserted during RD_WAIT aborts the read immediately; the SRAM result is discarded and the buffer is invalid.
- Address decode compares the full ADDR_W bits; there is no aliasing.
- Latency: hit, I/O access and write take 0 wait cycles; a miss takes 1 wait cycle.

Test Plan:
1. SRAM[0x0001]=0x51; read 0x0001 -> core_ready=0 for 1 cycle, then core_rdata=0x51 with ready=1, miss_count=1; read 0x0001 again -> ready=1 same cycle, sram_cs stays 0, miss_count stays 1.
2. Write 0x0004=0xAB -> sram_cs=1, sram_we=1, sram_wdata=0xAB in that cycle; then read 0x0004 -> hit returning 0xAB, no sram_cs.
3. Write 0x7FFF=0x3C -> io_out=0x3C after that edge, sram_cs=0; io_in=0x5A held 2 cycles, then read 0x7FFE -> 0x5A, ready=1 with no miss.
4. core_re=core_we=1 at 0x0008, wdata 0x11 -> SRAM write only, miss_count unchanged; next read 0x0008 hits with 0x11.
5. rst pulsed during RD_WAIT for 0x0010 -> outputs reset immediately, miss_count=0; after release, read 0x0010 misses again.
6. CNT_W=4, 20 reads to distinct addresses -> miss_count reaches 15 and holds at 15.

Source files
------------

// File: rtl/misao_mem_ctrl.sv
// Byte memory controller: one-entry read buffer, SRAM write-through, two memory-mapped I/O registers, read-miss counter.
// Latency: hits, I/O and writes complete at once, a miss costs one wait cycle. Backpressure: core_ready low while a miss is in flight.
module misao_mem_ctrl #(
  parameter int                 ADDR_W      = 15,
  parameter int                 DATA_W      = 8,
  parameter logic [ADDR_W-1:0]  IO_OUT_ADDR = 15'h7FFF,
  parameter logic [ADDR_W-1:0]  IO_IN_ADDR  = 15'h7FFE,
  parameter int                 SYNC_STAGES = 2,
  parameter int                 CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_re,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_ready,
  output logic              sram_cs,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic [DATA_W-1:0] io_in,
  output logic [DATA_W-1:0] io_out,
  output logic [CNT_W-1:0]  miss_count
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t                              state;
  logic                                buf_valid;
  logic [ADDR_W-1:0]                   buf_addr;
  logic [DATA_W-1:0]                   buf_data;
  logic [SYNC_STAGES-1:0][DATA_W-1:0]  sync_q;

  logic is_out, is_in, is_io, buf_hit, rd_req, wr_sram, rd_miss;

  // A simultaneous read and write is treated as a write only.
  assign is_out  = (core_addr == IO_OUT_ADDR);
  assign is_in   = (core_addr == IO_IN_ADDR);
  assign is_io   = is_out || is_in;
  assign buf_hit = buf_valid && (buf_addr == core_addr);
  assign rd_req  = core_re && !core_we;
  assign wr_sram = (state == IDLE) && core_we && !is_io;
  assign rd_miss = (state == IDLE) && rd_req && !is_io && !buf_hit;

  always_comb begin
    core_ready = 1'b0;
    core_rdata = '0;
    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = core_addr;
    sram_wdata = core_wdata;
    if (!rst) begin
      case (state)
        IDLE: begin
          core_ready = !rd_miss;
          if (rd_req && is_out)
            core_rdata = io_out;
          else if (rd_req && is_in)
            core_rdata = sync_q[SYNC_STAGES-1];
          else
            core_rdata = buf_data;
          sram_cs = wr_sram || rd_miss;
          sram_we = wr_sram;
        end
        RD_WAIT: begin
          core_ready = 1'b1;
          core_rdata = sram_rdata;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= io_in;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      buf_valid  <= 1'b0;
      buf_addr   <= '0;
      buf_data   <= '0;
      io_out     <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (core_we) begin
            if (is_out) begin
              io_out <= core_wdata;
            end else if (!is_in) begin
              buf_valid <= 1'b1;
              buf_addr  <= core_addr;
              buf_data  <= core_wdata;
            end
          end else if (rd_miss) begin
            state <= RD_WAIT;
            if (miss_count != {CNT_W{1'b1}})
              miss_count <= miss_count + 1'b1;
          end
        end
        RD_WAIT: begin
          // The core holds core_addr until ready, so it still names the missed byte.
          buf_valid <= 1'b1;
          buf_addr  <= core_addr;
          buf_data  <= sram_rdata;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_misao_mem_ctrl.sv
// Randomised scoreboard bench for misao_mem_ctrl with a byte-level reference model and SRAM model.
`timescale 1ns/1ps
module tb_misao_mem_ctrl;
  localparam int AW = 15;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam logic [AW-1:0] A_OUT = 15'h7FFF;
  localparam logic [AW-1:0] A_IN  = 15'h7FFE;

  logic clk = 1'b0;
  logic rst;
  logic core_re, core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;
  logic core_ready;
  logic sram_cs, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;
  logic [DW-1:0] io_in, io_out;
  logic [CW-1:0] miss_count;

  always #5 clk = ~clk;

  misao_mem_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .core_re(core_re), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_ready(core_ready),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .io_in(io_in), .io_out(io_out), .miss_count(miss_count)
  );

  // SRAM environment: synchronous, one-cycle read latency.
  logic [DW-1:0] sram_mem [0:32767];
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) sram_mem[sram_addr] = sram_wdata;
      else         sram_rdata <= sram_mem[sram_addr];
    end
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [0:32767];
  bit            m_bv;
  logic [AW-1:0] m_ba;
  int            m_misses;
  logic [DW-1:0] m_io_out, m_io_in;

  typedef struct {
    logic          rd;
    logic [DW-1:0] data;
    int            waits;
    logic [CW-1:0] miss;
    logic [DW-1:0] io_before;
    logic          cs_fin;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } exp_t;
  exp_t sb[$];

  int compared = 0;
  int mismatched = 0;
  bit mon_en = 1'b0;
  int mon_waits = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  function automatic exp_t predict(input logic re, input logic we,
                                   input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.rd = 1'b0; e.data = '0; e.waits = 0; e.cs_fin = 1'b0;
    e.io_before = m_io_out; e.addr = a; e.wdata = d;
    if (we) begin
      if (a == A_OUT) m_io_out = d;
      else if (a != A_IN) begin
        ref_mem[a] = d; m_bv = 1'b1; m_ba = a; e.cs_fin = 1'b1;
      end
    end else if (re) begin
      e.rd = 1'b1;
      if (a == A_OUT) e.data = m_io_out;
      else if (a == A_IN) e.data = m_io_in;
      else begin
        e.data = ref_mem[a];
        if (!(m_bv && m_ba == a)) begin
          e.waits = 1; m_misses++; m_bv = 1'b1; m_ba = a;
        end
      end
    end
    e.miss = (m_misses > 15) ? 4'd15 : 4'(m_misses);
    return e;
  endfunction

  // Drive one request and hold it until the DUT completes it; called at posedge+1.
  task automatic issue(input logic re, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    sb.push_back(predict(re, we, a, d));
    core_re = re; core_we = we; core_addr = a; core_wdata = d;
    n = 0;
    do begin @(negedge clk); n++; end while (!core_ready && n < 8);
    if (!core_ready) chk("ready_timeout", {31'd0, core_ready}, 32'd1);
    @(posedge clk); #1;
    core_re = 1'b0; core_we = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever a request completes.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && (core_re || core_we)) begin
      if (!core_ready) begin
        mon_waits++;
        chk("miss_cs_we", {30'd0, sram_cs, sram_we}, 32'd2);
        chk("miss_addr", 32'(sram_addr), 32'(core_addr));
      end else if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("waits", mon_waits, e.waits);
        mon_waits = 0;
        if (e.rd) chk("rdata", 32'(core_rdata), 32'(e.data));
        chk("miss_count", 32'(miss_count), 32'(e.miss));
        chk("io_out", 32'(io_out), 32'(e.io_before));
        chk("sram_cs_done", {31'd0, sram_cs}, {31'd0, e.cs_fin});
        if (e.cs_fin) begin
          chk("sram_we", {31'd0, sram_we}, 32'd1);
          chk("sram_addr", 32'(sram_addr), 32'(e.addr));
          chk("sram_wdata", 32'(sram_wdata), 32'(e.wdata));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] b;
    for (int i = 0; i < 32768; i++) begin
      b = 8'($urandom);
      sram_mem[i] = b;
      ref_mem[i] = b;
    end
    sram_mem[1] = 8'h51; ref_mem[1] = 8'h51;
    m_bv = 1'b0; m_ba = '0; m_misses = 0; m_io_out = '0; m_io_in = '0;
    rst = 1'b1; core_re = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    io_in = '0; sram_rdata = '0;
    #2;
    chk("rst_ready", {31'd0, core_ready}, 32'd0);
    chk("rst_cs", {31'd0, sram_cs}, 32'd0);
    chk("rst_rdata", 32'(core_rdata), 32'd0);
    chk("rst_miss", 32'(miss_count), 32'd0);
    chk("rst_io_out", 32'(io_out), 32'd0);
    idle(2);
    rst = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // 1: miss then hit on 0x0001
    issue(1'b1, 1'b0, 15'h0001, 8'h00);
    issue(1'b1, 1'b0, 15'h0001, 8'h00);
    // 2: write-through then hit
    issue(1'b0, 1'b1, 15'h0004, 8'hAB);
    issue(1'b1, 1'b0, 15'h0004, 8'h00);
    // 3: output register and synchronised input
    issue(1'b0, 1'b1, A_OUT, 8'h3C);
    chk("io_out_after_wr", 32'(io_out), 32'h3C);
    io_in = 8'h5A; m_io_in = 8'h5A;
    idle(2);
    issue(1'b1, 1'b0, A_IN, 8'h00);
    issue(1'b1, 1'b0, A_OUT, 8'h00);
    // 4: read+write together is a write
    issue(1'b1, 1'b1, 15'h0008, 8'h11);
    issue(1'b1, 1'b0, 15'h0008, 8'h00);

    // 5: reset during RD_WAIT
    mon_en = 1'b0;
    core_re = 1'b1; core_addr = 15'h0010;
    @(negedge clk);
    chk("rw_pre_ready", {31'd0, core_ready}, 32'd0);
    @(posedge clk); #1;
    chk("rw_wait_ready", {31'd0, core_ready}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rw_rst_ready", {31'd0, core_ready}, 32'd0);
    chk("rw_rst_cs", {31'd0, sram_cs}, 32'd0);
    chk("rw_rst_rdata", 32'(core_rdata), 32'd0);
    chk("rw_rst_miss", 32'(miss_count), 32'd0);
    chk("rw_rst_io_out", 32'(io_out), 32'd0);
    core_re = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_bv = 1'b0; m_misses = 0; m_io_out = '0;
    mon_en = 1'b1;
    idle(3);
    issue(1'b1, 1'b0, 15'h0010, 8'h00);
    issue(1'b1, 1'b0, A_IN, 8'h00);

    // 6: counter saturation with 20 distinct misses
    for (int i = 0; i < 20; i++)
      issue(1'b1, 1'b0, 15'(16'h0100 + i), 8'h00);
    chk("miss_saturated", 32'(miss_count), 32'd15);

    // Random traffic over a small address pool plus the I/O addresses
    for (int t = 0; t < 300; t++) begin
      int r, op;
      logic [AW-1:0] a;
      r = $urandom_range(0, 99);
      if (r < 5)       a = A_OUT;
      else if (r < 10) a = A_IN;
      else             a = 15'($urandom_range(0, 31));
      op = $urandom_range(0, 2);
      issue(op != 1, op != 0, a, 8'($urandom));
      r = $urandom_range(0, 2);
      if (r > 0) idle(r);
    end

    idle(2);
    chk("io_out_final", 32'(io_out), 32'(m_io_out));
    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
